imem_loader: RTL and testbench

Boot-time writer for the instruction memory read by the fetch stage. It accepts a little-endian byte stream from a host link, assembles the bytes into 32-bit instruction words, and writes them at consecutive word-aligned byte addresses. Until the image is complete it holds the core pipeline in reset, so the fetch stage starts at PC 0 on a fully loaded image.

---
 rtl/imem_loader_pkg.sv | 7 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 100 ++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and framing constants for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_SHIFT = 2;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into 32-bit words
//   clk, rst (async, active-low)  clock and reset
//   clr                           synchronous clear of lane counter and partial word
//   in_valid, in_data             byte accepted this cycle
//   word_valid, word              high with the complete word when the fourth lane arrives
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam int LW = $clog2(BYTES_PER_WORD);
  logic [LW-1:0] lane;
  logic [23:0]   sr;
  // Earlier bytes shift down so the first byte lands in word[7:0].
  assign word_valid = in_valid && lane == LW'(BYTES_PER_WORD - 1);
  assign word = {in_data, sr};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lane <= '0;
      sr   <= '0;
    end else if (clr) begin
      lane <= '0;
      sr   <= '0;
    end else if (in_valid) begin
      lane <= lane + 1'b1;
      sr   <= {in_data, sr[23:8]};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for instruction memory, holds the core in reset until loaded
//   clk, rst (async, active-low)  clock and reset
//   rx_valid, rx_data, rx_ready   host byte stream (transfer on rx_valid & rx_ready)
//   start                         re-arms the loader from DONE or ERROR
//   imem_we, imem_addr, imem_wdata  one-cycle word write, byte address 4*index
//   core_rst_n                    pipeline reset, released once the image is complete
//   loaded, load_err              image complete / transfer aborted
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        loaded,
  output logic        load_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(2 ** ADDR_WIDTH);
  state_t state, next;
  logic [7:0]          len_lo;
  logic [15:0]         word_count;
  logic [ADDR_WIDTH:0] word_index;
  logic [TW-1:0]       gap;
  logic [15:0]         hdr;
  logic                accept, active, tmo, wr, last, rdy_next, word_valid;
  logic [31:0]         word;
  assign accept = rx_valid && rx_ready;
  assign active = state == LEN_HI || state == DATA;
  assign tmo    = active && !accept && gap == TW'(TIMEOUT_CYCLES - 1);
  assign hdr    = {rx_data, len_lo};
  assign wr     = state == DATA && word_valid;
  // Stop accepting as soon as the final byte is in, so the write cycle cannot take a stray byte.
  assign last   = wr && {1'b0, word_count} == 17'(word_index) + 17'd1;
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != DATA),
    .in_valid  (accept && state == DATA),
    .in_data   (rx_data),
    .word_valid(word_valid),
    .word      (word)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LEN_LO;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      LEN_LO: if (accept) next = LEN_HI;
      LEN_HI:
        if (accept) next = hdr == '0 ? DONE : {1'b0, hdr} > CAP ? ERROR : DATA;
        else if (tmo) next = ERROR;
      // word_index has already advanced past the word being written in this cycle.
      DATA:
        if (imem_we && 17'(word_index) == {1'b0, word_count}) next = DONE;
        else if (tmo) next = ERROR;
      default: if (start) next = LEN_LO;
    endcase
    rdy_next = (next == LEN_LO || next == LEN_HI || next == DATA) && !last;
  end
  // Status outputs follow the next state so they are registered and glitch-free.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      loaded     <= 1'b0;
      load_err   <= 1'b0;
      len_lo     <= '0;
      word_count <= '0;
      word_index <= '0;
      gap        <= '0;
    end else begin
      rx_ready   <= rdy_next;
      imem_we    <= wr;
      core_rst_n <= next == DONE;
      loaded     <= next == DONE;
      load_err   <= next == ERROR;
      if (wr) begin
        imem_addr  <= 32'(word_index[ADDR_WIDTH-1:0]) << ADDR_SHIFT;
        imem_wdata <= word;
      end
      if (state == LEN_LO && accept) len_lo <= rx_data;
      if (state == LEN_HI && accept) word_count <= hdr;
      word_index <= state != DATA ? '0 : wr ? word_index + 1'b1 : word_index;
      gap        <= (accept || !active) ? '0 : gap + 1'b1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;
  logic        clk, rst, rx_valid, rx_ready, start, imem_we, core_rst_n, loaded, load_err;
  logic [7:0]  rx_data;
  logic [31:0] imem_addr, imem_wdata;
  int checks = 0, failures = 0, acc = 0;
  typedef struct { logic [31:0] a, d; } wr_t;
  wr_t exp_q[$];
  wr_t e_mon;
  typedef struct { logic [7:0] lo, hi; logic ld, er; } hdr_t;
  hdr_t tbl[4];

  imem_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .loaded(loaded), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc++;
    if (rst && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got addr=%h data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        e_mon = exp_q.pop_front();
        if (imem_addr !== e_mon.a || imem_wdata !== e_mon.d) begin
          failures++;
          $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e_mon.a, e_mon.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout_rx_ready", rx_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx);
    exp_q.push_back('{32'(idx * 4), w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int k);
    rx_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rx_ready"}, rx_ready, 0);
    chk({nm, "_imem_we"}, imem_we, 0);
    chk({nm, "_imem_addr"}, imem_addr, 0);
    chk({nm, "_imem_wdata"}, imem_wdata, 0);
    chk({nm, "_core_rst_n"}, core_rst_n, 0);
    chk({nm, "_loaded"}, loaded, 0);
    chk({nm, "_load_err"}, load_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int a0;
    tbl[0] = '{8'h00, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 8'h01, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h02, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1};
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; start = 1'b0;
    #2 rst = 1'b0;
    #1 chk_zero("reset");
    #19 rst = 1'b1;
    #1 chk("rel_rx_ready_low", rx_ready, 0);
    @(posedge clk); #1;
    chk("rel_rx_ready_high", rx_ready, 1);

    for (int i = 0; i < 4; i++) begin
      send_byte(tbl[i].lo);
      send_byte(tbl[i].hi);
      rx_valid = 1'b0;
      chk("hdr_loaded", loaded, tbl[i].ld);
      chk("hdr_load_err", load_err, tbl[i].er);
      chk("hdr_core_rst_n", core_rst_n, tbl[i].ld);
      chk("hdr_rx_ready", rx_ready, 0);
      pulse_start;
      chk("rearm_rx_ready", rx_ready, 1);
      chk("rearm_loaded", loaded, 0);
      chk("rearm_load_err", load_err, 0);
      chk("rearm_core_rst_n", core_rst_n, 0);
    end

    send_hdr(16'd2);
    exp_q.push_back('{32'h0, 32'h00000013});
    exp_q.push_back('{32'h4, 32'h00100093});
    send_byte(8'h13); send_byte(8'h00);
    start = 1'b1;
    send_byte(8'h00);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    rx_valid = 1'b0;
    chk("f2_we_last", imem_we, 1);
    chk("f2_core_rst_n_during_we", core_rst_n, 0);
    chk("f2_rx_ready_last", rx_ready, 0);
    @(posedge clk); #1;
    chk("f2_core_rst_n", core_rst_n, 1);
    chk("f2_loaded", loaded, 1);
    chk("f2_we_done", imem_we, 0);

    pulse_start;
    send_hdr(16'd1);
    exp_q.push_back('{32'h0, 32'h44332211});
    send_byte(8'h11); send_byte(8'h22);
    idle(14);
    send_byte(8'h33);
    chk("gap15_load_err", load_err, 0);
    idle(15);
    chk("gap_edge_load_err", load_err, 0);
    send_byte(8'h44);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("byte_wins_loaded", loaded, 1);

    pulse_start;
    send_hdr(16'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(15);
    chk("tmo_before_err", load_err, 0);
    idle(1);
    chk("tmo_err", load_err, 1);
    chk("tmo_core_rst_n", core_rst_n, 0);
    chk("tmo_rx_ready", rx_ready, 0);

    pulse_start;
    send_hdr(16'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    #2 rst = 1'b1;
    @(posedge clk); #1;
    send_hdr(16'd1);
    send_word(32'hEFBEADDE, 0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_reload_loaded", loaded, 1);

    pulse_start;
    a0 = acc;
    send_hdr(16'd2);
    send_word(32'hCAFEF00D, 0);
    send_word(32'h12345678, 1);
    rx_data = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_accepted", acc - a0, 10);
    chk("b2b_rx_ready", rx_ready, 0);
    chk("b2b_loaded", loaded, 1);
    rx_valid = 1'b0;

    pulse_start;
    send_hdr(16'd256);
    for (int i = 0; i < 256; i++) send_word($urandom, i);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("full_loaded", loaded, 1);
    chk("full_load_err", load_err, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
